// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter: grants one cacheline read or write at a time from NUM_CH
// requesters to the single cacheline adapter.
// The winner's index, operation, address and write data are latched for the
// whole transaction. The adapter response is steered back to the winner only.
// Optional feature macro: ARB_ROUND_ROBIN_EN selects rotating priority.
// When it is undefined, priority is fixed and channel 0 is highest.
module mem_line_arbiter #(
   parameter  int NUM_CH = 4,
   parameter  int ADDR_W = 32,
   parameter  int LINE_W = 256,
   localparam int GW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        ch_read,
   input  logic [NUM_CH-1:0]        ch_write,
   input  logic [NUM_CH*ADDR_W-1:0] ch_address,
   input  logic [NUM_CH*LINE_W-1:0] ch_wdata,
   output logic [NUM_CH-1:0]        ch_resp,
   output logic [NUM_CH*LINE_W-1:0] ch_rdata,
   input  logic                     mem_resp,
   input  logic [LINE_W-1:0]        mem_rdata,
   output logic [ADDR_W-1:0]        mem_address,
   output logic                     mem_read,
   output logic                     mem_write,
   output logic [LINE_W-1:0]        mem_wdata,
   output logic                     busy,
   output logic [GW-1:0]            grant_id
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t              state_r;
   logic [GW-1:0]       grant_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [LINE_W-1:0]   wdata_r;
   logic                op_read_r;
   logic                mem_read_r;
   logic                mem_write_r;
   logic                busy_r;

   logic [NUM_CH-1:0]   req_s;
   logic                any_req_s;
   logic [GW-1:0]       start_s;
   logic [GW-1:0]       win_s;
   logic                found_s;
   int                  idx_s;

`ifdef ARB_ROUND_ROBIN_EN
   logic [GW-1:0]       ptr_r;
   assign start_s = ptr_r;
`else
   assign start_s = {GW{1'b0}};
`endif

   assign req_s     = ch_read | ch_write;
   assign any_req_s = |req_s;

   // Winner is the first requesting channel at or after start_s, wrapping modulo NUM_CH.
   always_comb begin
      win_s   = {GW{1'b0}};
      found_s = 1'b0;
      idx_s   = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx_s = (int'(start_s) + k) % NUM_CH;
         if (!found_s && req_s[idx_s]) begin
            win_s   = GW'(idx_s);
            found_s = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Arbitration FSM: latch the winner in IDLE and hold the transaction until mem_resp.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= IDLE;
         grant_r     <= {GW{1'b0}};
         addr_r      <= {ADDR_W{1'b0}};
         wdata_r     <= {LINE_W{1'b0}};
         op_read_r   <= 1'b0;
         mem_read_r  <= 1'b0;
         mem_write_r <= 1'b0;
         busy_r      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         ptr_r       <= {GW{1'b0}};
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (any_req_s) begin
                  // A channel asking for both is given the read first; its write stays pending.
                  state_r     <= BUSY;
                  grant_r     <= win_s;
                  addr_r      <= ch_address[int'(win_s)*ADDR_W +: ADDR_W];
                  wdata_r     <= ch_wdata[int'(win_s)*LINE_W +: LINE_W];
                  op_read_r   <= ch_read[win_s];
                  mem_read_r  <= ch_read[win_s];
                  mem_write_r <= ~ch_read[win_s];
                  busy_r      <= 1'b1;
               end else begin
                  state_r     <= IDLE;
               end
            end
            BUSY: begin
               if (mem_resp) begin
                  state_r     <= IDLE;
                  mem_read_r  <= 1'b0;
                  mem_write_r <= 1'b0;
                  busy_r      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                  ptr_r       <= (grant_r == GW'(NUM_CH - 1)) ? {GW{1'b0}} : grant_r + 1'b1;
`endif
               end else begin
                  state_r     <= BUSY;
               end
            end
            default: begin
               state_r     <= IDLE;
               mem_read_r  <= 1'b0;
               mem_write_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   // Steer the adapter completion and read data to the current winner only.
   always_comb begin
      ch_resp  = {NUM_CH{1'b0}};
      ch_rdata = {(NUM_CH*LINE_W){1'b0}};
      if (state_r == BUSY) begin
         ch_resp[grant_r] = mem_resp;
         if (op_read_r) begin
            ch_rdata[int'(grant_r)*LINE_W +: LINE_W] = mem_rdata;
         end else begin
            ch_rdata = {(NUM_CH*LINE_W){1'b0}};
         end
      end else begin
         ch_resp  = {NUM_CH{1'b0}};
      end
   end

   assign mem_address = addr_r;
   assign mem_wdata   = wdata_r;
   assign mem_read    = mem_read_r;
   assign mem_write   = mem_write_r;
   assign busy        = busy_r;
   assign grant_id    = grant_r;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Randomized scoreboard bench for mem_line_arbiter.
// The driver models the requesters and the adapter and predicts each grant
// and each response from the priority rules. The monitor pops those
// predictions whenever the DUT presents a grant or a response.
module tb_mem_line_arbiter;
   localparam int NUM_CH = 4;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;
   localparam int GW     = 2;
   localparam int NCYC   = 3000;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NUM_CH-1:0]        ch_read, ch_write, ch_resp;
   logic [NUM_CH*ADDR_W-1:0] ch_address;
   logic [NUM_CH*LINE_W-1:0] ch_wdata, ch_rdata;
   logic                     mem_resp;
   logic [LINE_W-1:0]        mem_rdata;
   logic [ADDR_W-1:0]        mem_address;
   logic                     mem_read, mem_write, busy;
   logic [LINE_W-1:0]        mem_wdata;
   logic [GW-1:0]            grant_id;

   mem_line_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst(rst), .ch_read(ch_read), .ch_write(ch_write),
      .ch_address(ch_address), .ch_wdata(ch_wdata), .ch_resp(ch_resp),
      .ch_rdata(ch_rdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .busy(busy), .grant_id(grant_id)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                ch;
      bit                rd;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
   } grant_t;

   typedef struct {
      logic [NUM_CH-1:0]        resp;
      logic [NUM_CH*LINE_W-1:0] rdata;
   } resp_t;

   grant_t gq[$];
   resp_t  rq[$];

   int vectors    = 0;
   int miscompares = 0;

   // reference model state
   bit                prd[NUM_CH];
   bit                pwr[NUM_CH];
   logic [ADDR_W-1:0] a[NUM_CH];
   logic [LINE_W-1:0] d[NUM_CH];
   int                ptr  = 0;
   int                mst  = 0;     // 0: arbiter free, 1: transaction outstanding
   int                wcnt = 0;
   int                wch  = 0;
   bit                wrd  = 1'b0;

   task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] r;
      for (int i = 0; i < LINE_W/32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic apply();
      for (int i = 0; i < NUM_CH; i++) begin
         ch_read[i]                      = prd[i];
         ch_write[i]                     = pwr[i];
         ch_address[i*ADDR_W +: ADDR_W]  = a[i];
         ch_wdata[i*LINE_W +: LINE_W]    = d[i];
      end
   endtask

   // Pick the next winner from the pending requests by the priority rule.
   task automatic predict();
      grant_t g;
      bit     f = 1'b0;
      int     w = 0;
      for (int k = 0; k < NUM_CH; k++) begin
         int idx;
         idx = (ptr + k) % NUM_CH;
         if (!f && (prd[idx] || pwr[idx])) begin
            f = 1'b1;
            w = idx;
         end
      end
      if (f) begin
         g.ch = w; g.rd = prd[w]; g.addr = a[w]; g.wdata = d[w];
         gq.push_back(g);
         wch  = w;
         wrd  = prd[w];
         mst  = 1;
         wcnt = $urandom_range(0, 5) + 1;
      end
   endtask

   // Driver: requesters, adapter and prediction.
   initial begin
      resp_t r;
      bit    drop = 1'b0;
      bit    just_resp;
      bit    want_reset = 1'b0;
      int    rate;
      int    rq_kind;
      rst = 1'b1;
      ch_read = '0; ch_write = '0; ch_address = '0; ch_wdata = '0;
      mem_resp = 1'b0; mem_rdata = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         prd[i] = 1'b0; pwr[i] = 1'b0; a[i] = '0; d[i] = '0;
      end
      #1 rst = 1'b0;
      #11;
      check("reset_busy", busy, 0);
      check("reset_mem_read", mem_read, 0);
      check("reset_mem_write", mem_write, 0);
      check("reset_grant_id", grant_id, 0);
      check("reset_mem_address", mem_address, 0);
      check("reset_mem_wdata", mem_wdata, 0);
      check("reset_ch_resp", ch_resp, 0);
      @(posedge clk); #2 rst = 1'b1;

      for (int cyc = 0; cyc < NCYC; cyc++) begin
         @(posedge clk); #2;
         rate = (cyc < NCYC/2) ? 80 : 15;
         if (cyc == 700 || cyc == 2200) want_reset = 1'b1;
         mem_resp  = 1'b0;
         mem_rdata = rand_line();
         just_resp = 1'b0;
         if (drop) begin
            if (wrd) prd[wch] = 1'b0; else pwr[wch] = 1'b0;
            drop = 1'b0;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if ($urandom_range(3) == 0) begin
               a[i] = $urandom;
               d[i] = rand_line();
            end
            if (!prd[i] && !pwr[i] && $urandom_range(99) < rate) begin
               rq_kind = $urandom_range(1, 3);
               prd[i]  = (rq_kind & 1) != 0;
               pwr[i]  = (rq_kind & 2) != 0;
            end
         end
         if (mst == 1) begin
            wcnt--;
            if (wcnt == 0) begin
               mem_resp = 1'b1;
               r.resp = '0; r.resp[wch] = 1'b1; r.rdata = '0;
               if (wrd) r.rdata[wch*LINE_W +: LINE_W] = mem_rdata;
               rq.push_back(r);
`ifdef ARB_ROUND_ROBIN_EN
               ptr = (wch + 1) % NUM_CH;
`endif
               drop = 1'b1;
               mst = 0;
               just_resp = 1'b1;
            end
         end else if ($urandom_range(7) == 0) begin
            // stray adapter pulse while idle must be ignored
            mem_resp = 1'b1;
            r.resp = '0; r.rdata = '0;
            rq.push_back(r);
         end
         apply();
         if (mst == 1 && want_reset && mem_resp == 1'b0) begin
            want_reset = 1'b0;
            #5 rst = 1'b0;
            #1;
            check("abort_busy", busy, 0);
            check("abort_mem_read", mem_read, 0);
            check("abort_mem_write", mem_write, 0);
            check("abort_grant_id", grant_id, 0);
            check("abort_ch_resp", ch_resp, 0);
            @(posedge clk); #2 rst = 1'b1;
            mst = 0;
            ptr = 0;
            predict();
         end else if (mst == 0 && !just_resp) begin
            predict();
         end
      end
      @(posedge clk); #2 mem_resp = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      check("grants_left_unseen", gq.size(), 0);
      check("responses_left_unseen", rq.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Monitor: compare each grant and each response against the scoreboard.
   initial begin
      grant_t cur;
      resp_t  r;
      bit     have = 1'b0;
      bit     pb   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            pb = 1'b0;
            have = 1'b0;
         end else begin
            if (busy && !pb) begin
               if (gq.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL unexpected_grant: got grant_id %0d, expected no grant", grant_id);
               end else begin
                  cur = gq.pop_front();
                  have = 1'b1;
                  check("grant_id", grant_id, cur.ch);
               end
            end
            if (busy && have) begin
               check("mem_address", mem_address, cur.addr);
               check("mem_wdata", mem_wdata, cur.wdata);
               check("mem_read", mem_read, cur.rd);
               check("mem_write", mem_write, !cur.rd);
            end else if (!busy) begin
               check("idle_mem_op", {mem_read, mem_write}, 0);
               have = 1'b0;
            end
            if (mem_resp || ch_resp != '0) begin
               if (rq.size() == 0) begin
                  vectors++; miscompares++;
                  $display("FAIL unexpected_ch_resp: got %b, expected no response", ch_resp);
               end else begin
                  r = rq.pop_front();
                  check("ch_resp", ch_resp, r.resp);
                  for (int i = 0; i < NUM_CH; i++)
                     check($sformatf("ch_rdata[%0d]", i), ch_rdata[i*LINE_W +: LINE_W], r.rdata[i*LINE_W +: LINE_W]);
               end
            end
            pb = busy;
         end
      end
   end

endmodule

// File: doc/mem_line_arbiter.md
# mem_line_arbiter

Parametrised N-channel cacheline arbiter between cache/prefetch requesters and the single cacheline adapter; successor to the fixed four-source prefetch arbiter. Grants one read or write transaction at a time and latches the winner's address, operation and write data for the whole transaction. Routes the adapter response back to the winner only. Priority is fixed (channel 0 highest) or rotating round-robin, selected at compile time.

## Interface
- NUM_CH, 4, number of requester channels (≥2); suggested map: 0 icache, 1 dcache, 2.. prefetchers
- ADDR_W, 32, address width
- LINE_W, 256, cacheline width
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous and active-low (asserted at 0); clears all state immediately
- ch_read  in  NUM_CH  per-channel read request, level, held until ch_resp
- ch_write  in  NUM_CH  per-channel write request, level, held until ch_resp
- ch_address  in  NUM_CH*ADDR_W  channel i at bits [i*ADDR_W +: ADDR_W]
- ch_wdata  in  NUM_CH*LINE_W  channel i at bits [i*LINE_W +: LINE_W]
- ch_resp  out  NUM_CH  one-hot completion pulse to the winner
- ch_rdata  out  NUM_CH*LINE_W  read data; only the winner's slice is nonzero
- mem_resp  in  1  adapter completion pulse
- mem_rdata  in  LINE_W  adapter read data
- mem_address  out  ADDR_W  latched address of current transaction
- mem_read  out  1  read in progress
- mem_write  out  1  write in progress
- mem_wdata  out  LINE_W  latched write data
- busy  out  1  transaction in progress
- grant_id  out  max(1,$clog2(NUM_CH))  index of current winner

## Operation
- States: IDLE, BUSY.
- IDLE: request vector req[i] = ch_read[i] | ch_write[i]. If any set, select winner per priority policy; on the edge latch winner index, address, wdata, op (read if ch_read[w], else write); go BUSY. Otherwise stay IDLE.
- Channel with both ch_read and ch_write set: read serviced first; write stays pending and competes again.
- BUSY: mem_read or mem_write = latched op, mem_address/mem_wdata = latched values, busy=1. ch_resp[w] = mem_resp and ch_rdata slice w = mem_rdata combinationally; all other ch_resp/ch_rdata = 0. ch_rdata driven on reads only (0 during writes).
- BUSY with mem_resp=1: go IDLE on next edge; priority pointer updated (round-robin only). mem_resp=0: stay BUSY, no timeout.
- Requester input changes during BUSY do not affect the transaction in flight.
- mem_resp while IDLE is ignored; no ch_resp generated.
- Reset: state=IDLE, pointer=0, latched address/wdata/grant_id=0; all outputs 0. Reset during BUSY aborts immediately; mem_read/mem_write drop with no ch_resp.

## Timing
- Request visible before edge k in IDLE → mem_read/mem_write high from cycle k+1.
- mem_resp in cycle m → ch_resp[w] same cycle m; mem_read/mem_write low from m+1 (one IDLE cycle).
- Earliest next grant: evaluated in IDLE cycle m+1, memory op asserted from m+2. Minimum request-to-request spacing on the memory side: 2 cycles plus adapter latency.
- No combinational path from ch_* inputs to mem_* outputs; mem_resp→ch_resp and mem_rdata→ch_rdata are combinational.

## Configuration
- ARB_ROUND_ROBIN_EN defined: rotating priority. Search starts at pointer p, wraps modulo NUM_CH; after each completed transaction p = (w+1) mod NUM_CH (p=0 when w=NUM_CH-1). Reset aborts do not advance p.
- Undefined: fixed priority, lowest index wins; pointer logic absent; behaviour matches the previous arbiter ordering for icache(0), dcache(1), prefetch(2+).

## Test plan
- Single read: ch_read[1]=1, address 0x0000_1240; mem_resp after 3 cycles with rdata=0xA5..A5 → mem_read high exactly from grant+1 to resp cycle, ch_resp=4'b0010, slice 1=0xA5..A5, others 0; mem_read low next cycle.
- Write latching: ch_write[2]=1, wdata=0xDEAD..BEEF; requester changes address/wdata mid-BUSY → mem_address/mem_wdata stay at original values until mem_resp.
- Contention, fixed priority (macro off): ch_read=4'b1111 held, each serviced in turn → grant order 0,1,2,3 as each drops its request after resp; with all held forever, channel 0 granted repeatedly.
- Contention, round-robin (macro on): ch_read=4'b1111 held for 8 transactions → grant_id sequence 0,1,2,3,0,1,2,3; wrap from 3 to 0 verified.
- Read+write same channel: ch_read[1]=ch_write[1]=1 → read serviced first, then write granted after IDLE cycle.
- Async reset mid-BUSY: rst=0 in middle of clock cycle during read → mem_read, busy, grant_id drop to 0 before next edge; no ch_resp; after release, pending requests re-arbitrate from pointer 0.
